// File: rtl/eep_arbiter.sv
// Arbiter for the shared EEPROM port: fair PID/CMD grant, timed write strobes,
// registered read data and one-cycle done pulses.
module eep_arbiter #(
  parameter int WR_CYCLES = 2400000,
  parameter int CNT_W     = 22
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pid_req,
  input  logic [1:0]  i_pid_addr,
  output logic        o_pid_done,
  input  logic        i_cmd_req,
  input  logic        i_cmd_wr,
  input  logic [1:0]  i_cmd_addr,
  input  logic [13:0] i_cmd_wdata,
  output logic        o_cmd_done,
  output logic [13:0] o_rd_data,
  output logic        o_busy,
  output logic [1:0]  o_eep_addr,
  output logic        o_eep_cs_n,
  output logic        o_eep_r_w_n,
  output logic [13:0] o_eep_wdata,
  output logic        o_chrg_pmp_en,
  input  logic [13:0] i_eep_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic OWN_PID = 1'b0;
  localparam logic OWN_CMD = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            r_state;
  state_t            w_next;
  logic              r_owner;
  logic              r_last_owner;
  logic [1:0]        r_addr;
  logic [13:0]       r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic [13:0]       r_rd_data;
  logic              r_cs_n;
  logic              r_r_w_n;
  logic              r_chrg;
  logic              r_busy;
  logic              r_pid_done;
  logic              r_cmd_done;

  logic              w_grant;
  logic              w_grant_owner;
  logic              w_cnt_last;

  assign w_cnt_last = (r_cnt == CNT_LAST);

  // Grant decision: only meaningful in IDLE; on contention the requester
  // that did not own the port last time wins.
  always_comb begin
    w_grant       = 1'b0;
    w_grant_owner = r_last_owner;
    if (r_state == S_IDLE) begin
      if (i_pid_req && i_cmd_req) begin
        w_grant       = 1'b1;
        w_grant_owner = ~r_last_owner;
      end else if (i_pid_req) begin
        w_grant       = 1'b1;
        w_grant_owner = OWN_PID;
      end else if (i_cmd_req) begin
        w_grant       = 1'b1;
        w_grant_owner = OWN_CMD;
      end else begin
        w_grant       = 1'b0;
        w_grant_owner = r_last_owner;
      end
    end else begin
      w_grant       = 1'b0;
      w_grant_owner = r_last_owner;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          if ((w_grant_owner == OWN_CMD) && i_cmd_wr) begin
            w_next = S_WR;
          end else begin
            w_next = S_RD;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RD:   w_next = S_DONE;
      S_WR: begin
        if (w_cnt_last) begin
          w_next = S_DONE;
        end else begin
          w_next = S_WR;
        end
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Transaction context captured at grant; later input changes are ignored.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_owner      <= OWN_CMD;
      r_last_owner <= OWN_CMD;
      r_addr       <= 2'd0;
      r_wdata      <= 14'd0;
    end else if (w_grant) begin
      r_owner      <= w_grant_owner;
      r_last_owner <= w_grant_owner;
      if (w_grant_owner == OWN_CMD) begin
        r_addr  <= i_cmd_addr;
        r_wdata <= i_cmd_wdata;
      end else begin
        r_addr  <= i_pid_addr;
      end
    end
  end

  // Programming-time counter, active only while writing.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (r_state == S_WR) begin
      if (w_cnt_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  // Read data capture during the single RD cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_data <= 14'd0;
    end else if (r_state == S_RD) begin
      r_rd_data <= i_eep_rdata;
    end
  end

  // Strobes, busy and done are registered from the next state, so they line
  // up with the state they describe and never follow a req input directly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cs_n     <= 1'b1;
      r_r_w_n    <= 1'b1;
      r_chrg     <= 1'b0;
      r_busy     <= 1'b0;
      r_pid_done <= 1'b0;
      r_cmd_done <= 1'b0;
    end else begin
      r_cs_n     <= ~((w_next == S_RD) || (w_next == S_WR));
      r_r_w_n    <= ~(w_next == S_WR);
      r_chrg     <= (w_next == S_WR);
      r_busy     <= (w_next != S_IDLE);
      r_pid_done <= (w_next == S_DONE) && (r_owner == OWN_PID);
      r_cmd_done <= (w_next == S_DONE) && (r_owner == OWN_CMD);
    end
  end

  assign o_pid_done    = r_pid_done;
  assign o_cmd_done    = r_cmd_done;
  assign o_rd_data     = r_rd_data;
  assign o_busy        = r_busy;
  assign o_eep_addr    = r_addr;
  assign o_eep_cs_n    = r_cs_n;
  assign o_eep_r_w_n   = r_r_w_n;
  assign o_eep_wdata   = r_wdata;
  assign o_chrg_pmp_en = r_chrg;

endmodule

// File: tb/tb_eep_arbiter.sv
// Directed bench for eep_arbiter: expected done events are queued by the
// stimulus and checked by an independent monitor.
module tb_eep_arbiter;

  localparam int WR_CYCLES = 4;
  localparam int CNT_W     = 3;

  logic        clk;
  logic        rst;
  logic        pid_req;
  logic [1:0]  pid_addr;
  logic        pid_done;
  logic        cmd_req;
  logic        cmd_wr;
  logic [1:0]  cmd_addr;
  logic [13:0] cmd_wdata;
  logic        cmd_done;
  logic [13:0] rd_data;
  logic        busy;
  logic [1:0]  eep_addr;
  logic        eep_cs_n;
  logic        eep_r_w_n;
  logic [13:0] eep_wdata;
  logic        chrg_pmp_en;
  logic [13:0] eep_rdata;

  eep_arbiter #(.WR_CYCLES(WR_CYCLES), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_pid_req(pid_req), .i_pid_addr(pid_addr), .o_pid_done(pid_done),
    .i_cmd_req(cmd_req), .i_cmd_wr(cmd_wr), .i_cmd_addr(cmd_addr),
    .i_cmd_wdata(cmd_wdata), .o_cmd_done(cmd_done),
    .o_rd_data(rd_data), .o_busy(busy),
    .o_eep_addr(eep_addr), .o_eep_cs_n(eep_cs_n), .o_eep_r_w_n(eep_r_w_n),
    .o_eep_wdata(eep_wdata), .o_chrg_pmp_en(chrg_pmp_en), .i_eep_rdata(eep_rdata)
  );

  typedef struct {
    bit          pid;
    logic [13:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          rd_strobes = 0;
  int          wr_strobes = 0;
  logic [13:0] mem [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Fixed EEPROM contents, addressed by the DUT.
  always_comb eep_rdata = mem[eep_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit pid, input logic [13:0] data, input int at);
    exp_t e;
    e.pid = pid; e.data = data; e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Strobe cycle counters.
  always @(negedge clk) begin
    if (!eep_cs_n && eep_r_w_n) rd_strobes++;
    if (!eep_cs_n && !eep_r_w_n && chrg_pmp_en) wr_strobes++;
  end

  // Monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (pid_done || cmd_done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_done: got pid_done=%0b cmd_done=%0b, expected none (cycle %0d)",
                 pid_done, cmd_done, cyc);
      end else begin
        e = sb.pop_front();
        check("done_pid", pid_done, e.pid);
        check("done_cmd", cmd_done, !e.pid);
        check("done_cycle", cyc, e.cyc);
        check("rd_data", rd_data, e.data);
      end
    end
  end

  task automatic both_reads(input logic [1:0] pa, input logic [13:0] pd,
                            input logic [1:0] ca, input logic [13:0] cd);
    int t0;
    t0 = cyc;
    pid_addr = pa; pid_req = 1'b1;
    cmd_addr = ca; cmd_wr = 1'b0; cmd_req = 1'b1;
    push(1'b1, pd, t0 + 2);
    push(1'b0, cd, t0 + 5);
    step(3);
    pid_req = 1'b0;
    @(negedge clk);
    check("both_idle_busy", busy, 1'b0);
    step(1);
    @(negedge clk);
    check("both_cmd_cs", eep_cs_n, 1'b0);
    check("both_cmd_addr", eep_addr, ca);
    step(2);
    cmd_req = 1'b0;
  endtask

  initial begin
    int t0;
    int s0;
    mem[0] = 14'h0111; mem[1] = 14'h1234; mem[2] = 14'h2222; mem[3] = 14'h3333;
    rst = 1'b1; pid_req = 1'b0; pid_addr = 2'd0;
    cmd_req = 1'b0; cmd_wr = 1'b0; cmd_addr = 2'd0; cmd_wdata = 14'd0;
    step(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cs_n", eep_cs_n, 1'b1);
    check("rst_r_w_n", eep_r_w_n, 1'b1);
    check("rst_chrg", chrg_pmp_en, 1'b0);
    check("rst_addr", eep_addr, 2'd0);
    check("rst_wdata", eep_wdata, 14'd0);
    check("rst_rd_data", rd_data, 14'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_dones", {pid_done, cmd_done}, 2'b00);

    // PID read of address 1
    step(1);
    t0 = cyc; s0 = rd_strobes;
    pid_addr = 2'b01; pid_req = 1'b1;
    push(1'b1, 14'h1234, t0 + 2);
    step(1);
    @(negedge clk);
    check("pid_rd_cs", eep_cs_n, 1'b0);
    check("pid_rd_rw", eep_r_w_n, 1'b1);
    check("pid_rd_addr", eep_addr, 2'b01);
    check("pid_rd_busy", busy, 1'b1);
    step(2);
    pid_req = 1'b0;
    step(1);
    check("pid_rd_strobes", rd_strobes - s0, 1);

    // CMD write, inputs changed after grant
    t0 = cyc; s0 = wr_strobes;
    cmd_addr = 2'b10; cmd_wdata = 14'h0A5A; cmd_wr = 1'b1; cmd_req = 1'b1;
    push(1'b0, 14'h1234, t0 + 5);
    step(1);
    @(negedge clk);
    check("wr_cs", eep_cs_n, 1'b0);
    check("wr_rw", eep_r_w_n, 1'b0);
    check("wr_chrg", chrg_pmp_en, 1'b1);
    check("wr_wdata", eep_wdata, 14'h0A5A);
    check("wr_addr", eep_addr, 2'b10);
    step(1);
    cmd_wdata = 14'h3FFF; cmd_addr = 2'b00; cmd_wr = 1'b0;
    @(negedge clk);
    check("wr_wdata_latched", eep_wdata, 14'h0A5A);
    check("wr_addr_latched", eep_addr, 2'b10);
    step(4);
    cmd_req = 1'b0;
    @(negedge clk);
    check("wr_strobes", wr_strobes - s0, WR_CYCLES);
    check("wr_after_chrg", chrg_pmp_en, 1'b0);
    check("wr_after_cs", eep_cs_n, 1'b1);
    check("wr_after_wdata", eep_wdata, 14'h0A5A);

    // Contention out of reset, twice
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    both_reads(2'b10, 14'h2222, 2'b11, 14'h3333);
    both_reads(2'b00, 14'h0111, 2'b01, 14'h1234);

    // PID request arriving during a write waits for IDLE
    t0 = cyc; s0 = wr_strobes;
    cmd_addr = 2'b01; cmd_wdata = 14'h0155; cmd_wr = 1'b1; cmd_req = 1'b1;
    push(1'b0, 14'h1234, t0 + 5);
    step(2);
    pid_addr = 2'b11; pid_req = 1'b1;
    push(1'b1, 14'h3333, t0 + 8);
    @(negedge clk);
    check("pre_chrg", chrg_pmp_en, 1'b1);
    step(4);
    cmd_req = 1'b0;
    check("pre_strobes", wr_strobes - s0, WR_CYCLES);
    step(3);
    pid_req = 1'b0;

    // Reset in the second write cycle aborts with no done
    t0 = cyc;
    cmd_addr = 2'b00; cmd_wdata = 14'h1111; cmd_wr = 1'b1; cmd_req = 1'b1;
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0; cmd_req = 1'b0; cmd_wr = 1'b0;
    @(negedge clk);
    check("abort_chrg", chrg_pmp_en, 1'b0);
    check("abort_cs", eep_cs_n, 1'b1);
    check("abort_rw", eep_r_w_n, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_rd_data", rd_data, 14'd0);
    step(4);
    t0 = cyc;
    pid_addr = 2'b01; pid_req = 1'b1;
    push(1'b1, 14'h1234, t0 + 2);
    step(3);
    pid_req = 1'b0;

    // CMD read with req held through done: two transactions
    t0 = cyc;
    cmd_addr = 2'b10; cmd_wr = 1'b0; cmd_req = 1'b1;
    push(1'b0, 14'h2222, t0 + 2);
    push(1'b0, 14'h0111, t0 + 5);
    step(1);
    cmd_addr = 2'b00;
    @(negedge clk);
    check("held_addr_latched", eep_addr, 2'b10);
    step(3);
    @(negedge clk);
    check("held_second_cs", eep_cs_n, 1'b0);
    check("held_second_addr", eep_addr, 2'b00);
    step(2);
    cmd_req = 1'b0;
    step(3);

    for (int i = 0; i < 20 && sb.size() != 0; i++) step(1);
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
